// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pipe_skid_reg #(
    parameter int WIDTH       = 71,
    parameter bit ZERO_BUBBLE = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             accept_s;
    logic             consume_s;

    // State register: valid bits and counter carry reset, payloads do not.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_q      <= {CNT_W{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_q      <= stall_d;
        end
    end

    // Payload registers.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    // Next-state logic; the (main,skid) valid pair is the state encoding.
    always_comb begin
        accept_s     = in_valid & ~skid_valid_q;
        consume_s    = main_valid_q & out_ready;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (main_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (accept_s) begin
                        main_d       = in_data;
                        main_valid_d = 1'b1;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b10: begin
                    if (consume_s && accept_s) begin
                        main_d = in_data;
                    end else if (consume_s) begin
                        main_valid_d = 1'b0;
                    end else if (accept_s) begin
                        skid_d       = in_data;
                        skid_valid_d = 1'b1;
                    end else begin
                        main_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (consume_s) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end else begin
                        skid_valid_d = 1'b1;
                    end
                end
                default: begin
                    // Illegal (0,1) pair: recover to EMPTY.
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs depend only on registered state; no path from out_ready.
    always_comb begin
        in_ready     = ~skid_valid_q;
        out_valid    = main_valid_q;
        occupancy    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
        stall_cycles = stall_q;
        if (ZERO_BUBBLE && !main_valid_q) begin
            out_data = {WIDTH{1'b0}};
        end else begin
            out_data = main_q;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: two instances (zeroing/2-bit counter and
// non-zeroing/16-bit counter) share stimulus; directed table plus random run.
module tb_pipe_skid_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [7:0]  a_out_data, b_out_data;
    logic [1:0]  a_occ, b_occ;
    logic [1:0]  a_stall;
    logic [15:0] b_stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    int st_a = 0;
    int st_b = 0;

    typedef struct {
        logic       r, f, iv;
        logic [7:0] d;
        logic       ordy, ov;
        logic [7:0] od;
        logic       ir;
        logic [1:0] occ, st;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(8), .ZERO_BUBBLE(1'b1), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_ready(out_ready), .flush(flush), .occupancy(a_occ),
        .stall_cycles(a_stall)
    );

    pipe_skid_reg #(.WIDTH(8), .ZERO_BUBBLE(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(out_ready), .flush(flush), .occupancy(b_occ),
        .stall_cycles(b_stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: held bundles are a FIFO of at most two entries.
    task automatic model_step(input logic r, input logic f, input logic iv,
                              input logic [7:0] d, input logic ordy);
        int  sz;
        bit  acc;
        sz  = mq.size();
        acc = iv && (sz < 2);
        if (r) begin
            mq.delete();
            st_a = 0;
            st_b = 0;
        end else begin
            if (sz > 0 && !ordy) begin
                if (st_a < 3) st_a++;
                if (st_b < 65535) st_b++;
            end
            if (f) begin
                mq.delete();
            end else begin
                if (sz > 0 && ordy) void'(mq.pop_front());
                if (acc) mq.push_back(d);
            end
        end
    endtask

    task automatic check_b_model();
        check("b_out_valid", {31'd0, b_out_valid}, {31'd0, mq.size() > 0});
        check("b_in_ready", {31'd0, b_in_ready}, {31'd0, mq.size() < 2});
        check("b_occupancy", {30'd0, b_occ}, mq.size());
        check("b_stall", {16'd0, b_stall}, st_b);
        if (mq.size() > 0) check("b_out_data", {24'd0, b_out_data}, {24'd0, mq[0]});
    endtask

    task automatic check_a_model();
        check("a_out_valid", {31'd0, a_out_valid}, {31'd0, mq.size() > 0});
        check("a_out_data", {24'd0, a_out_data}, (mq.size() > 0) ? {24'd0, mq[0]} : 32'd0);
        check("a_in_ready", {31'd0, a_in_ready}, {31'd0, mq.size() < 2});
        check("a_occupancy", {30'd0, a_occ}, mq.size());
        check("a_stall", {30'd0, a_stall}, st_a);
    endtask

    // Called at a negedge: drive, advance one edge, return at the next negedge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [7:0] d, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        model_step(r, f, iv, d, ordy);
        @(posedge clk);
        @(negedge clk);
        check_b_model();
    endtask

    task automatic add(input logic r, input logic f, input logic iv, input logic [7:0] d,
                       input logic ordy, input logic ov, input logic [7:0] od,
                       input logic ir, input logic [1:0] occ, input logic [1:0] st);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ; v.st = st;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // inputs: rst flush in_valid in_data out_ready | expected: ov od ir occ stall
        add(1'b1, 1'b0, 1'b0, 8'd0,  1'b0,  1'b0, 8'd0,  1'b1, 2'd0, 2'd0);
        add(1'b0, 1'b0, 1'b1, 8'd1,  1'b1,  1'b1, 8'd1,  1'b1, 2'd1, 2'd0);
        add(1'b0, 1'b0, 1'b1, 8'd2,  1'b1,  1'b1, 8'd2,  1'b1, 2'd1, 2'd0);
        add(1'b0, 1'b0, 1'b1, 8'd3,  1'b1,  1'b1, 8'd3,  1'b1, 2'd1, 2'd0);
        add(1'b0, 1'b0, 1'b1, 8'd4,  1'b1,  1'b1, 8'd4,  1'b1, 2'd1, 2'd0);
        add(1'b0, 1'b0, 1'b0, 8'd0,  1'b1,  1'b0, 8'd0,  1'b1, 2'd0, 2'd0);
        add(1'b0, 1'b0, 1'b1, 8'd10, 1'b1,  1'b1, 8'd10, 1'b1, 2'd1, 2'd0);
        add(1'b0, 1'b0, 1'b1, 8'd11, 1'b0,  1'b1, 8'd10, 1'b0, 2'd2, 2'd1);
        add(1'b0, 1'b0, 1'b1, 8'd12, 1'b0,  1'b1, 8'd10, 1'b0, 2'd2, 2'd2);
        add(1'b0, 1'b0, 1'b1, 8'd12, 1'b1,  1'b1, 8'd11, 1'b1, 2'd1, 2'd2);
        add(1'b0, 1'b0, 1'b1, 8'd12, 1'b1,  1'b1, 8'd12, 1'b1, 2'd1, 2'd2);
        add(1'b0, 1'b0, 1'b0, 8'd0,  1'b1,  1'b0, 8'd0,  1'b1, 2'd0, 2'd2);
        add(1'b0, 1'b0, 1'b1, 8'd20, 1'b0,  1'b1, 8'd20, 1'b1, 2'd1, 2'd2);
        add(1'b0, 1'b0, 1'b1, 8'd21, 1'b0,  1'b1, 8'd20, 1'b0, 2'd2, 2'd3);
        add(1'b0, 1'b1, 1'b1, 8'd99, 1'b0,  1'b0, 8'd0,  1'b1, 2'd0, 2'd3);
        add(1'b0, 1'b0, 1'b0, 8'd0,  1'b1,  1'b0, 8'd0,  1'b1, 2'd0, 2'd3);
        add(1'b1, 1'b0, 1'b0, 8'd0,  1'b0,  1'b0, 8'd0,  1'b1, 2'd0, 2'd0);
        add(1'b0, 1'b0, 1'b1, 8'd5,  1'b0,  1'b1, 8'd5,  1'b1, 2'd1, 2'd0);
        add(1'b0, 1'b0, 1'b0, 8'd0,  1'b0,  1'b1, 8'd5,  1'b1, 2'd1, 2'd1);
        add(1'b0, 1'b0, 1'b0, 8'd0,  1'b0,  1'b1, 8'd5,  1'b1, 2'd1, 2'd2);
        add(1'b0, 1'b0, 1'b0, 8'd0,  1'b0,  1'b1, 8'd5,  1'b1, 2'd1, 2'd3);
        add(1'b0, 1'b0, 1'b0, 8'd0,  1'b0,  1'b1, 8'd5,  1'b1, 2'd1, 2'd3);
        add(1'b0, 1'b0, 1'b0, 8'd0,  1'b0,  1'b1, 8'd5,  1'b1, 2'd1, 2'd3);
        add(1'b0, 1'b0, 1'b0, 8'd0,  1'b0,  1'b1, 8'd5,  1'b1, 2'd1, 2'd3);
        add(1'b0, 1'b1, 1'b0, 8'd0,  1'b0,  1'b0, 8'd0,  1'b1, 2'd0, 2'd3);
        add(1'b1, 1'b0, 1'b0, 8'd0,  1'b0,  1'b0, 8'd0,  1'b1, 2'd0, 2'd0);
        add(1'b0, 1'b0, 1'b1, 8'd30, 1'b0,  1'b1, 8'd30, 1'b1, 2'd1, 2'd0);
        add(1'b0, 1'b0, 1'b1, 8'd31, 1'b0,  1'b1, 8'd30, 1'b0, 2'd2, 2'd1);
        add(1'b1, 1'b0, 1'b1, 8'd32, 1'b1,  1'b0, 8'd0,  1'b1, 2'd0, 2'd0);
        add(1'b0, 1'b0, 1'b1, 8'd33, 1'b0,  1'b1, 8'd33, 1'b1, 2'd1, 2'd0);
        add(1'b1, 1'b1, 1'b1, 8'd40, 1'b1,  1'b0, 8'd0,  1'b1, 2'd0, 2'd0);
        add(1'b0, 1'b0, 1'b0, 8'd0,  1'b1,  1'b0, 8'd0,  1'b1, 2'd0, 2'd0);

        @(negedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            check($sformatf("vec%0d_out_valid", i), {31'd0, a_out_valid}, {31'd0, tbl[i].ov});
            check($sformatf("vec%0d_out_data", i), {24'd0, a_out_data}, {24'd0, tbl[i].od});
            check($sformatf("vec%0d_in_ready", i), {31'd0, a_in_ready}, {31'd0, tbl[i].ir});
            check($sformatf("vec%0d_occupancy", i), {30'd0, a_occ}, {30'd0, tbl[i].occ});
            check($sformatf("vec%0d_stall", i), {30'd0, a_stall}, {30'd0, tbl[i].st});
        end

        // Sustained throughput: one bundle per cycle, never backpressured.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b1, 8'(8'h50 + k), 1'b1);
            check("thru_out_data", {24'd0, a_out_data}, 32'h50 + k);
            check("thru_in_ready", {31'd0, a_in_ready}, 32'd1);
            check("thru_occupancy", {30'd0, a_occ}, 32'd1);
        end

        // Randomised run against the FIFO model.
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 ($urandom_range(0, 99) < ((k / 200) % 2 == 0 ? 70 : 30)) ? 1'b1 : 1'b0);
            check_a_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
